aurora_link_mon: RTL and testbench

AURORA_LINK_MON -- requirements
Module: aurora_link_mon

---
 rtl/aurora_link_mon.sv | 129 ++++++++++++
 tb/tb_aurora_link_mon.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/aurora_link_mon.sv
// aurora_link_mon: Aurora channel_up supervisor with retry/fault FSM; define AURORA_LINK_MON_STAT_EN to build drop/soft-error counters
module aurora_link_mon #(
    parameter int WAIT_UP_CYC  = 100_000_000,
    parameter int STABLE_CYC   = 1_000,
    parameter int DROP_CYC     = 64,
    parameter int RST_HOLD_CYC = 1_000,
    parameter int MAX_RETRY    = 8
) (
    input  logic        aurora_axis_aclk,
    input  logic        aurora_axis_areset,
    input  logic        i_aurora_init_flag,
    input  logic        i_channel_up,
    input  logic        i_soft_err,
    input  logic        i_fault_clr,
    output logic        o_sfp_rst_req,
    output logic        o_link_ok,
    output logic        o_link_fault,
    output logic [7:0]  o_retry_cnt,
    output logic [15:0] o_drop_cnt,
    output logic [15:0] o_soft_err_cnt
);
    typedef enum logic [2:0] {IDLE, WAIT_UP, LINK_UP, RST_REQ, FAULT} state_t;
    localparam logic [7:0] MAX_R = 8'(MAX_RETRY);
    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d, stable_q, stable_d;
    logic [7:0]  retry_q, retry_d, retry_inc;
    logic        armed_q, armed_d;
    logic        link_ok_q, fault_q, rst_req_q;
    logic        drop_evt;
    // timer_q is the timeout in WAIT_UP, the low-run length in LINK_UP and the hold count in RST_REQ
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 32'd1;
        stable_d  = '0;
        retry_d   = retry_q;
        armed_d   = armed_q;
        drop_evt  = 1'b0;
        retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        case (state_q)
            IDLE: begin
                armed_d = armed_q | ~i_aurora_init_flag;
                if (armed_q && i_aurora_init_flag) state_d = WAIT_UP;
            end
            WAIT_UP: begin
                stable_d = i_channel_up ? stable_q + 32'd1 : '0;
                if (!i_aurora_init_flag) begin
                    state_d = IDLE;
                end else if (stable_d == STABLE_CYC) begin
                    state_d = LINK_UP;
                    retry_d = '0;
                end else if (timer_d == WAIT_UP_CYC) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc >= MAX_R) ? FAULT : RST_REQ;
                end
            end
            LINK_UP: begin
                timer_d = i_channel_up ? '0 : timer_q + 32'd1;
                if (!i_aurora_init_flag) begin
                    state_d = IDLE;
                end else if (timer_d == DROP_CYC) begin
                    drop_evt = 1'b1;
                    retry_d  = retry_inc;
                    state_d  = (retry_inc >= MAX_R) ? FAULT : RST_REQ;
                end
            end
            RST_REQ: begin
                armed_d = 1'b0;
                if (timer_d == RST_HOLD_CYC) state_d = IDLE;
            end
            FAULT: begin
                if (i_fault_clr) begin
                    retry_d = '0;
                    state_d = RST_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) timer_d = '0;
    end
    always_ff @(posedge aurora_axis_aclk or posedge aurora_axis_areset) begin
        if (aurora_axis_areset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            stable_q  <= '0;
            retry_q   <= '0;
            armed_q   <= 1'b1;
            link_ok_q <= 1'b0;
            fault_q   <= 1'b0;
            rst_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            stable_q  <= stable_d;
            retry_q   <= retry_d;
            armed_q   <= armed_d;
            link_ok_q <= state_d == LINK_UP;
            fault_q   <= state_d == FAULT;
            rst_req_q <= state_d == RST_REQ;
        end
    end
    assign o_sfp_rst_req = rst_req_q;
    assign o_link_ok     = link_ok_q;
    assign o_link_fault  = fault_q;
    assign o_retry_cnt   = retry_q;
`ifdef AURORA_LINK_MON_STAT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d, soft_err_cnt_q, soft_err_cnt_d;
    always_comb begin
        drop_cnt_d     = (drop_evt && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        soft_err_cnt_d = (i_soft_err && state_q == LINK_UP && soft_err_cnt_q != 16'hFFFF)
                         ? soft_err_cnt_q + 16'd1 : soft_err_cnt_q;
    end
    always_ff @(posedge aurora_axis_aclk or posedge aurora_axis_areset) begin
        if (aurora_axis_areset) begin
            drop_cnt_q     <= '0;
            soft_err_cnt_q <= '0;
        end else begin
            drop_cnt_q     <= drop_cnt_d;
            soft_err_cnt_q <= soft_err_cnt_d;
        end
    end
    assign o_drop_cnt     = drop_cnt_q;
    assign o_soft_err_cnt = soft_err_cnt_q;
`else
    logic unused_stat;
    assign unused_stat    = i_soft_err | drop_evt;
    assign o_drop_cnt     = '0;
    assign o_soft_err_cnt = '0;
`endif
endmodule

// File: tb/tb_aurora_link_mon.sv
// tb_aurora_link_mon: directed bench for aurora_link_mon with short timing parameters
module tb_aurora_link_mon;
    localparam int W = 1000;
    localparam int S = 50;
    localparam int D = 64;
    localparam int H = 20;
    localparam int M = 3;
`ifdef AURORA_LINK_MON_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flag = 1'b0, cu = 1'b0, serr = 1'b0, fclr = 1'b0;
    logic        rst_req, link_ok, link_fault;
    logic [7:0]  retry;
    logic [15:0] drop_cnt, serr_cnt;
    int          checks = 0;
    int          failures = 0;

    aurora_link_mon #(
        .WAIT_UP_CYC(W), .STABLE_CYC(S), .DROP_CYC(D), .RST_HOLD_CYC(H), .MAX_RETRY(M)
    ) dut (
        .aurora_axis_aclk(clk),
        .aurora_axis_areset(rst),
        .i_aurora_init_flag(flag),
        .i_channel_up(cu),
        .i_soft_err(serr),
        .i_fault_clr(fclr),
        .o_sfp_rst_req(rst_req),
        .o_link_ok(link_ok),
        .o_link_fault(link_fault),
        .o_retry_cnt(retry),
        .o_drop_cnt(drop_cnt),
        .o_soft_err_cnt(serr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // leaves the bench at the negedge right after the WAIT_UP entry edge
    task automatic start_attempt();
        flag = 1'b0;
        tick(1);
        flag = 1'b1;
        tick(1);
    endtask

    // called at the negedge right after RST_REQ entry
    task automatic hold_check(input string tag);
        tick(H - 1);
        check({tag, "_hold_last"}, rst_req, 1);
        tick(1);
        check({tag, "_hold_end"}, rst_req, 0);
    endtask

    initial begin
        tick(2);
        check("rst_req_in_rst", rst_req, 0);
        check("link_ok_in_rst", link_ok, 0);
        check("fault_in_rst", link_fault, 0);
        check("retry_in_rst", retry, 0);
        check("drop_in_rst", drop_cnt, 0);
        check("serr_in_rst", serr_cnt, 0);
        rst = 1'b0;
        tick(2);

        // timeout with channel_up never rising
        start_attempt();
        tick(W - 1);
        check("tmo_before", rst_req, 0);
        tick(1);
        check("tmo_rst_req", rst_req, 1);
        check("tmo_retry", retry, 1);
        check("tmo_drop", drop_cnt, 0);
        hold_check("tmo");

        // init_flag still high after RST_REQ must not restart the attempt
        cu = 1'b1;
        serr = 1'b1;
        tick(S + 5);
        serr = 1'b0;
        check("stale_flag_link", link_ok, 0);
        check("stale_flag_rst", rst_req, 0);
        check("serr_not_linkup", serr_cnt, 0);

        // clean link-up
        cu = 1'b0;
        start_attempt();
        cu = 1'b1;
        tick(S - 1);
        check("up_early", link_ok, 0);
        tick(1);
        check("up_link_ok", link_ok, 1);
        check("up_retry", retry, 0);

        for (int i = 0; i < 5; i++) begin
            serr = 1'b1;
            tick(1);
            serr = 1'b0;
            tick(1);
        end
        check("serr_cnt", serr_cnt, STAT ? 5 : 0);

        // short dropout survives, full dropout restarts
        cu = 1'b0;
        tick(D - 1);
        check("short_drop_link", link_ok, 1);
        cu = 1'b1;
        tick(1);
        check("short_drop_after", link_ok, 1);
        check("short_drop_rst", rst_req, 0);
        cu = 1'b0;
        tick(D - 1);
        check("drop_pre", link_ok, 1);
        tick(1);
        check("drop_link_ok", link_ok, 0);
        check("drop_rst_req", rst_req, 1);
        check("drop_retry", retry, 1);
        check("drop_cnt", drop_cnt, STAT ? 1 : 0);
        hold_check("drop");

        // second failure, then third goes to FAULT
        start_attempt();
        tick(W);
        check("r2_rst_req", rst_req, 1);
        check("r2_retry", retry, 2);
        hold_check("r2");
        start_attempt();
        tick(W);
        check("fault_set", link_fault, 1);
        check("fault_no_rst", rst_req, 0);
        check("fault_retry", retry, M);
        tick(10);
        check("fault_holds", link_fault, 1);
        fclr = 1'b1;
        tick(1);
        fclr = 1'b0;
        check("clr_rst_req", rst_req, 1);
        check("clr_fault", link_fault, 0);
        check("clr_retry", retry, 0);

        // asynchronous reset in the middle of RST_REQ
        tick(3);
        #2 rst = 1'b1;
        #1;
        check("arst_rst_req", rst_req, 0);
        check("arst_retry", retry, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_serr", serr_cnt, 0);
        tick(2);
        rst = 1'b0;
        cu = 1'b1;
        tick(S + 2);
        check("restart_link", link_ok, 1);

        // init_flag dropping out of LINK_UP is not a failure
        flag = 1'b0;
        tick(1);
        check("flagfall_link", link_ok, 0);
        check("flagfall_retry", retry, 0);
        check("flagfall_rst", rst_req, 0);
        check("flagfall_drop", drop_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
